// File: rtl/sqrt_iter_pkg.sv
// Shared definitions for the iterative square-root unit.
//   state_t     : control FSM encoding (IDLE / RUN / DONE)
//   sqrt_out_w  : root width for a given radicand width and fractional bits
//   sqrt_cfg_ok : elaboration-time legality check of the parameter set
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int sqrt_out_w(input int width, input int frac);
        return width / 2 + frac;
    endfunction

    // WIDTH must be even and >= 2, and STEPS must divide the root width.
    function automatic bit sqrt_cfg_ok(input int width, input int frac, input int steps);
        int ow;
        ow = sqrt_out_w(width, frac);
        return (width >= 2) && (width % 2 == 0) && (frac >= 0) &&
               (steps >= 1) && (steps <= ow) && (ow % steps == 0);
    endfunction

endpackage

// File: rtl/sqrt_iter_if.sv
// Streaming handshake bundle for sqrt_iter.
//   in_valid/in_ready/in_x            : radicand input channel
//   out_valid/out_ready/out_root/out_rem : result output channel
//   busy                              : unit is iterating
// slave  : the square-root unit side
// master : the producer/consumer side
interface sqrt_iter_if
    import sqrt_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0
);
    localparam int OUT_W = sqrt_out_w(WIDTH, FRAC_BITS);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_root;
    logic [OUT_W:0]   out_rem;
    logic             busy;

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_root, out_rem, busy
    );

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_root, out_rem, busy
    );

endinterface

// File: rtl/sqrt_iter_step.sv
// One restoring square-root digit step (purely combinational).
//   rem_i  : partial remainder so far (OUT_W+1 bits)
//   root_i : partial root so far
//   pair_i : next two radicand bits, MSB pair first
//   rem_o / root_o : updated remainder and root
module sqrt_step #(
    parameter int OUT_W = 16
) (
    input  logic [OUT_W:0]   rem_i,
    input  logic [OUT_W-1:0] root_i,
    input  logic [1:0]       pair_i,
    output logic [OUT_W:0]   rem_o,
    output logic [OUT_W-1:0] root_o
);
    localparam int RW = OUT_W + 1;

    logic [OUT_W+2:0] rem_sh;
    logic [OUT_W+2:0] trial;
    logic             ge;

    always_comb begin
        rem_sh = {rem_i, pair_i};
        trial  = {1'b0, root_i, 2'b01};
        ge     = (rem_sh >= trial);
        // The updated remainder never exceeds 2*root, so it always fits OUT_W+1 bits.
        rem_o  = ge ? RW'(rem_sh - trial) : rem_sh[OUT_W:0];
        root_o = (root_i << 1) | OUT_W'(ge);
    end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer / fixed-point square root with valid/ready streaming.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : sqrt_iter_if slave (in_valid/in_ready/in_x,
//                out_valid/out_ready/out_root/out_rem, busy)
// Result: out_root = floor(sqrt(x * 4^FRAC_BITS)), out_rem = x*4^FRAC_BITS - root^2,
// available OUT_W/STEPS cycles after accept.
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0,
    parameter int STEPS     = 1
) (
    input  logic       clk,
    input  logic       reset,
    sqrt_iter_if.slave bus
);
    localparam int OUT_W = sqrt_out_w(WIDTH, FRAC_BITS);
    localparam int EXT_W = 2 * OUT_W;
    localparam int N_CYC = OUT_W / STEPS;
    localparam int CNT_W = $clog2(N_CYC + 1);

    if (!sqrt_cfg_ok(WIDTH, FRAC_BITS, STEPS)) begin : g_cfg_err
        $error("sqrt_iter: WIDTH must be even and >= 2, and STEPS must divide OUT_W");
    end

    state_t           state_q, state_d;
    logic [EXT_W-1:0] x_q, x_d;
    logic [OUT_W-1:0] root_q, root_d, root_nxt;
    logic [OUT_W:0]   rem_q, rem_d, rem_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready;
    logic             accept;

    // STEPS digit stages chained within one cycle; stage g consumes radicand pair g.
    for (genvar g = 0; g < STEPS; g++) begin : g_step
        logic [OUT_W:0]   rem_in, rem_out;
        logic [OUT_W-1:0] root_in, root_out;

        if (g == 0) begin : g_first
            assign rem_in  = rem_q;
            assign root_in = root_q;
        end else begin : g_next
            assign rem_in  = g_step[g-1].rem_out;
            assign root_in = g_step[g-1].root_out;
        end

        sqrt_step #(
            .OUT_W (OUT_W)
        ) u_step (
            .rem_i  (rem_in),
            .root_i (root_in),
            .pair_i (x_q[EXT_W-1-2*g -: 2]),
            .rem_o  (rem_out),
            .root_o (root_out)
        );
    end

    assign rem_nxt  = g_step[STEPS-1].rem_out;
    assign root_nxt = g_step[STEPS-1].root_out;

    always_comb begin
        // Gated by reset so the unit never advertises readiness during the reset cycle.
        in_ready = !reset && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
        accept   = in_ready && bus.in_valid;

        state_d = state_q;
        x_d     = x_q;
        root_d  = root_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    // Extended radicand is x << 2*FRAC_BITS, left-aligned in EXT_W bits.
                    x_d                    = '0;
                    x_d[EXT_W-1 -: WIDTH]  = bus.in_x;
                    root_d                 = '0;
                    rem_d                  = '0;
                    cnt_d                  = CNT_W'(N_CYC);
                    state_d                = RUN;
                end else if ((state_q == DONE) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                x_d    = x_q << (2 * STEPS);
                root_d = root_nxt;
                rem_d  = rem_nxt;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_root  = root_q;
    assign bus.out_rem   = rem_q;

endmodule

// File: tb/tb_sqrt_iter.sv
module tb_sqrt_iter;

    localparam int W  = 32;
    localparam int FA = 0;
    localparam int SA = 1;
    localparam int NA = 16;
    localparam int FB = 8;
    localparam int SB = 4;
    localparam int NB = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sqrt_iter_if #(.WIDTH(W), .FRAC_BITS(FA)) bus_a ();
    sqrt_iter_if #(.WIDTH(W), .FRAC_BITS(FB)) bus_b ();

    sqrt_iter #(.WIDTH(W), .FRAC_BITS(FA), .STEPS(SA)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sqrt_iter #(.WIDTH(W), .FRAC_BITS(FB), .STEPS(SB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        longint unsigned root;
        longint unsigned rem;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned acc_a[$];
    int unsigned acc_b[$];
    bit          shown_a = 1'b0;
    bit          shown_b = 1'b0;
    bit          rnd_rdy = 1'b0;
    int unsigned cyc     = 0;
    int          tests   = 0;
    int          fails   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic fail_msg(input string name, input string what);
        tests++;
        fails++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned lo = 0;
        longint unsigned hi = 65536;
        longint unsigned mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // Monitor / scoreboard for instance A
    always @(negedge clk) begin
        if (reset) begin
            qa.delete();
            acc_a.delete();
            shown_a = 1'b0;
        end else begin
            if (bus_a.in_valid && bus_a.in_ready) acc_a.push_back(cyc + 1);
            if (bus_a.out_valid && !shown_a) begin
                shown_a = 1'b1;
                if (acc_a.size() == 0) fail_msg("a_latency", "out_valid with no accepted operand");
                else check("a_latency", 64'(cyc - acc_a.pop_front()), 64'(NA));
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                shown_a = 1'b0;
                if (qa.size() == 0) begin
                    fail_msg("a_unexpected", $sformatf("result root %0d delivered, required none", bus_a.out_root));
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    check("a_root", 64'(bus_a.out_root), e.root);
                    check("a_rem", 64'(bus_a.out_rem), e.rem);
                end
            end
        end
    end

    // Monitor / scoreboard for instance B
    always @(negedge clk) begin
        if (reset) begin
            qb.delete();
            acc_b.delete();
            shown_b = 1'b0;
        end else begin
            if (bus_b.in_valid && bus_b.in_ready) acc_b.push_back(cyc + 1);
            if (bus_b.out_valid && !shown_b) begin
                shown_b = 1'b1;
                if (acc_b.size() == 0) fail_msg("b_latency", "out_valid with no accepted operand");
                else check("b_latency", 64'(cyc - acc_b.pop_front()), 64'(NB));
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                shown_b = 1'b0;
                if (qb.size() == 0) begin
                    fail_msg("b_unexpected", $sformatf("result root %0d delivered, required none", bus_b.out_root));
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    check("b_root", 64'(bus_b.out_root), e.root);
                    check("b_rem", 64'(bus_b.out_rem), e.rem);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) bus_a.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input bit sel, input logic [31:0] x,
                        input longint unsigned r, input longint unsigned m);
        exp_t        e;
        int unsigned n = 0;
        e.root = r;
        e.rem  = m;
        if (sel) begin
            qb.push_back(e);
            bus_b.in_x = x;
            bus_b.in_valid = 1'b1;
        end else begin
            qa.push_back(e);
            bus_a.in_x = x;
            bus_a.in_valid = 1'b1;
        end
        forever begin
            @(negedge clk);
            if (sel ? bus_b.in_ready : bus_a.in_ready) break;
            n++;
            if (n > 200) begin
                fail_msg("send_timeout", $sformatf("sel %0d in_ready 0 for %0d cycles, required 1", sel, n));
                break;
            end
        end
        @(posedge clk);
        #1;
        // Scramble in_x after accept: the unit must ignore it while running.
        if (sel) begin
            bus_b.in_valid = 1'b0;
            bus_b.in_x = ~x;
        end else begin
            bus_a.in_valid = 1'b0;
            bus_a.in_x = ~x;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0)
            fail_msg("drain_timeout", $sformatf("%0d/%0d results outstanding, required 0", qa.size(), qb.size()));
        @(posedge clk);
        #1;
    endtask

    logic [31:0]     va_x[12] = '{32'd0, 32'd16, 32'd17, 32'hFFFF_FFFF, 32'd1, 32'd2,
                                  32'd3, 32'd4, 32'd1000000, 32'd999999, 32'hFFFE_0001, 32'hFFFE_0000};
    longint unsigned va_r[12] = '{0, 4, 4, 65535, 1, 1, 1, 2, 1000, 999, 65535, 65534};
    longint unsigned va_m[12] = '{0, 0, 1, 131070, 0, 1, 2, 0, 0, 1998, 0, 131068};

    logic [31:0]     vb_x[6] = '{32'd2, 32'd16, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd3};
    longint unsigned vb_r[6] = '{362, 1024, 16777215, 0, 256, 443};
    longint unsigned vb_m[6] = '{28, 0, 33488895, 0, 0, 359};

    initial begin
        reset = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_x = '0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_x = '0; bus_b.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_a", 64'(bus_a.in_ready), 0);
        check("rst_in_ready_b", 64'(bus_b.in_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready_a", 64'(bus_a.in_ready), 1);
        check("post_rst_in_ready_b", 64'(bus_b.in_ready), 1);
        check("post_rst_out_valid", 64'(bus_a.out_valid), 0);
        check("post_rst_busy", 64'(bus_a.busy), 0);
        check("post_rst_root", 64'(bus_a.out_root), 0);
        check("post_rst_rem", 64'(bus_a.out_rem), 0);
        @(posedge clk);
        #1;

        // Directed integer vectors, back-to-back with out_ready high
        for (int i = 0; i < 12; i++) begin
            send(1'b0, va_x[i], va_r[i], va_m[i]);
            if (i == 0) begin
                @(negedge clk);
                check("busy_in_run", 64'(bus_a.busy), 1);
                @(posedge clk);
                #1;
            end
        end
        wait_idle();

        // Fixed-point, 4 digits per cycle
        for (int i = 0; i < 6; i++) send(1'b1, vb_x[i], vb_r[i], vb_m[i]);
        wait_idle();

        // Backpressure: result must hold and in_ready stay low
        begin
            int n = 0;
            bus_a.out_ready = 1'b0;
            send(1'b0, 32'd81, 9, 0);
            do begin
                @(negedge clk);
                n++;
            end while (!bus_a.out_valid && n < 100);
            if (!bus_a.out_valid) fail_msg("bp_wait", "out_valid never rose, required 1");
            @(posedge clk);
            #1;
            bus_a.in_x = 32'd100;
            bus_a.in_valid = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check("bp_valid", 64'(bus_a.out_valid), 1);
                check("bp_root", 64'(bus_a.out_root), 9);
                check("bp_rem", 64'(bus_a.out_rem), 0);
                check("bp_in_ready", 64'(bus_a.in_ready), 0);
            end
            @(posedge clk);
            #1 bus_a.out_ready = 1'b1;
            send(1'b0, 32'd100, 10, 0);
            wait_idle();
        end

        // Reset 5 cycles into RUN aborts the operation
        send(1'b0, 32'd12345, 111, 24);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_rst_in_ready", 64'(bus_a.in_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(bus_a.out_valid), 0);
        check("abort_busy", 64'(bus_a.busy), 0);
        check("abort_root", 64'(bus_a.out_root), 0);
        check("abort_rem", 64'(bus_a.out_rem), 0);
        check("abort_in_ready", 64'(bus_a.in_ready), 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(bus_a.out_valid), 0);
        end
        @(posedge clk);
        #1;

        // Random stream with random gaps and random out_ready
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0]     x;
            longint unsigned r;
            int              gap;
            x   = (i % 4 == 0) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
            r   = isqrt(64'(x));
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(1'b0, x, r, 64'(x) - r * r);
        end
        wait_idle();
        rnd_rdy = 1'b0;
        bus_a.out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
